// File: rtl/whack_button_encoder.sv
// whack_button_encoder
//   Debounces the five whack buttons and reports each new press once, encoded
//   with the same 3-bit mole number that drives the mole LEDs. Sits between the
//   board pushbuttons and the game-control FSM.
//
//   Optional feature (define HIT_COMPARE_EN): compares each report against the
//   current mole number and pulses hit or miss alongside btn_valid.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a new level is accepted (>=1)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_raw    in   [4:0] asynchronous active-high buttons, bit i <-> LED bit i
//   btn_code   out  [2:0] code of the last reported press (0 = multi-press)
//   btn_valid  out  one-cycle pulse, btn_code/btn_multi valid this cycle
//   btn_multi  out  more than one debounced button high at the press event
//   busy       out  high while waiting for every button to be released
//   mole_num   in   [2:0] current mole number (HIT_COMPARE_EN only)
//   hit        out  pulse with btn_valid on a matching press (HIT_COMPARE_EN only)
//   miss       out  pulse with btn_valid otherwise (HIT_COMPARE_EN only)
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a debounced press; the first rise is reported
// WAIT  | press reported, further rises ignored until all buttons are up

module whack_button_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [2:0] btn_code,
  output logic       btn_valid,
  output logic       btn_multi,
  output logic       busy
`ifdef HIT_COMPARE_EN
  ,
  input  logic [2:0] mole_num,
  output logic       hit,
  output logic       miss
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  state_t state, state_next;

  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       db;
  logic [4:0]       db_q;
  logic [CNT_W-1:0] cnt [5];

  logic [4:0] rise;
  logic       single;
  logic [2:0] code_next;
  logic       multi_next;
  logic       report;

  // Inverse of the LED map; only meaningful for a one-hot input.
  function automatic logic [2:0] encode(input logic [4:0] v);
    case (v)
      5'b00001: encode = 3'd1;
      5'b01000: encode = 3'd2;
      5'b00010: encode = 3'd3;
      5'b00100: encode = 3'd4;
      5'b10000: encode = 3'd5;
      default:  encode = 3'd0;
    endcase
  endfunction

  // Synchroniser and per-bit debounce. A counter only runs while the
  // synchronised level disagrees with the accepted level, so any glitch back
  // to the accepted level restarts the qualification window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise       = db & ~db_q;
  assign single     = (db != 5'd0) && ((db & (db - 5'd1)) == 5'd0);
  assign code_next  = single ? encode(db) : 3'd0;
  assign multi_next = !single;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (|rise)     state_next = WAIT_REL;
      WAIT_REL: if (db == 5'd0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == WAIT_REL);
    report = (state == IDLE) && (|rise);
  end

  // Report registers: the pulse lands one cycle after the rise is seen, and
  // code/multi hold their value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_valid <= 1'b0;
      btn_code  <= 3'd0;
      btn_multi <= 1'b0;
    end else begin
      btn_valid <= report;
      if (report) begin
        btn_code  <= code_next;
        btn_multi <= multi_next;
      end
    end
  end

`ifdef HIT_COMPARE_EN
  logic [2:0] mole_norm;
  logic       hit_next;

  // LED codes 6 and 7 alias moles 2 and 1.
  always_comb begin
    case (mole_num)
      3'd6:    mole_norm = 3'd2;
      3'd7:    mole_norm = 3'd1;
      default: mole_norm = mole_num;
    endcase
  end

  assign hit_next = !multi_next && (mole_norm != 3'd0) && (code_next == mole_norm);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end else begin
      hit  <= report && hit_next;
      miss <= report && !hit_next;
    end
  end
`endif

endmodule

// File: tb/tb_whack_button_encoder.sv
// Testbench for whack_button_encoder with DEBOUNCE_CYCLES = 4.
// Directed scenarios plus a randomized run compared cycle by cycle against a
// behavioural model that describes the button behaviour as a sliding window of
// synchronised samples.

module tb_whack_button_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = 5'd0;
  logic [2:0] btn_code;
  logic       btn_valid;
  logic       btn_multi;
  logic       busy;
`ifdef HIT_COMPARE_EN
  logic [2:0] mole_num = 3'd0;
  logic       hit;
  logic       miss;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  whack_button_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_code  (btn_code),
    .btn_valid (btn_valid),
    .btn_multi (btn_multi),
    .busy      (busy)
`ifdef HIT_COMPARE_EN
    ,
    .mole_num  (mole_num),
    .hit       (hit),
    .miss      (miss)
`endif
  );

  // ---------------- behavioural reference model ----------------
  logic [4:0] m_raw_d1, m_raw_d2;   // raw samples seen 1 and 2 edges ago
  logic [4:0] m_hist [D];           // last D synchronised samples, [0] newest
  logic [4:0] m_level, m_level_prev;
  bit         m_busy;
  logic       e_valid, e_multi;
  logic [2:0] e_code;
`ifdef HIT_COMPARE_EN
  logic       e_hit, e_miss;
`endif

  function automatic logic [2:0] ref_code(input logic [4:0] v);
    int codes [5] = '{1, 3, 4, 2, 5};
    int ones = 0;
    int idx  = 0;
    for (int i = 0; i < 5; i++) if (v[i]) begin ones++; idx = i; end
    return (ones == 1) ? 3'(codes[idx]) : 3'd0;
  endfunction

  task automatic model_step();
    logic [4:0] synced;
    logic [4:0] newly_high;
    bit         stable;
    if (rst) begin
      m_raw_d1 = '0; m_raw_d2 = '0;
      for (int j = 0; j < D; j++) m_hist[j] = '0;
      m_level = '0; m_level_prev = '0; m_busy = 0;
      e_valid = 0; e_code = '0; e_multi = 0;
`ifdef HIT_COMPARE_EN
      e_hit = 0; e_miss = 0;
`endif
      return;
    end
    newly_high = m_level & ~m_level_prev;
    e_valid = 0;
`ifdef HIT_COMPARE_EN
    e_hit = 0; e_miss = 0;
`endif
    if (!m_busy && newly_high != 0) begin
      e_valid = 1;
      e_code  = ref_code(m_level);
      e_multi = (e_code == 0);
`ifdef HIT_COMPARE_EN
      begin
        int mn = (mole_num == 6) ? 2 : (mole_num == 7) ? 1 : int'(mole_num);
        e_hit  = !e_multi && mn != 0 && int'(e_code) == mn;
        e_miss = !e_hit;
      end
`endif
      m_busy = 1;
    end else if (m_busy && m_level == 0) begin
      m_busy = 0;
    end
    m_level_prev = m_level;
    synced   = m_raw_d2;
    m_raw_d2 = m_raw_d1;
    m_raw_d1 = btn_raw;
    for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = synced;
    // A bit takes a new level once the last D samples all disagree with it.
    for (int i = 0; i < 5; i++) begin
      stable = 1;
      for (int j = 0; j < D; j++) if (m_hist[j][i] == m_level[i]) stable = 0;
      if (stable) m_level[i] = synced[i];
    end
  endtask

  // Every clock edge goes through here so the model tracks the DUT exactly.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit found);
    found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      tick();
      if (btn_valid) found = 1;
    end
  endtask

  task automatic release_all(output int pulses, output bit dropped);
    btn_raw = 5'd0;
    pulses  = 0;
    dropped = 0;
    for (int k = 0; k < 30 && !dropped; k++) begin
      tick();
      if (btn_valid) pulses++;
      if (!busy) dropped = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_raw = 5'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 5'd0;
    repeat (3) tick();
    total++; if (btn_valid !== 1'b0) $display("FAIL reset_valid got %0d want 0", btn_valid); else pass_cnt++;
    total++; if (btn_code !== 3'd0) $display("FAIL reset_code got %0d want 0", btn_code); else pass_cnt++;
    total++; if (btn_multi !== 1'b0) $display("FAIL reset_multi got %0d want 0", btn_multi); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", busy); else pass_cnt++;
  endtask

  task automatic test_latency();
    int pulses;
    bit dropped;
    int drop_at;
    rst = 1'b0;
    btn_raw = 5'b01000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (btn_valid !== (k == 7)) $display("FAIL latency_edge%0d got %0d want %0d", k, btn_valid, (k == 7));
      else pass_cnt++;
    end
    total++; if (btn_code !== 3'd2) $display("FAIL latency_code got %0d want 2", btn_code); else pass_cnt++;
    total++; if (btn_multi !== 1'b0) $display("FAIL latency_multi got %0d want 0", btn_multi); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL latency_busy got %0d want 1", busy); else pass_cnt++;
    btn_raw = 5'd0;
    pulses = 0; dropped = 0; drop_at = 0;
    for (int k = 1; k <= 20 && !dropped; k++) begin
      tick();
      if (btn_valid) pulses++;
      if (!busy) begin dropped = 1; drop_at = k; end
    end
    total++; if (drop_at != 7) $display("FAIL release_busy_drop got edge %0d want edge 7", drop_at); else pass_cnt++;
    total++; if (pulses != 0) $display("FAIL release_pulse got %0d want 0", pulses); else pass_cnt++;
  endtask

  task automatic test_single_bits();
    int want [5] = '{1, 3, 4, 2, 5};
    bit found;
    int pulses;
    bit dropped;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 5'(1 << i);
      wait_valid(20, found);
      total++;
      if (!found || btn_code !== 3'(want[i]) || btn_multi !== 1'b0)
        $display("FAIL single_bit%0d got valid=%0d code=%0d multi=%0d want valid=1 code=%0d multi=0",
                 i, found, btn_code, btn_multi, want[i]);
      else pass_cnt++;
      release_all(pulses, dropped);
      total++;
      if (pulses != 0 || !dropped)
        $display("FAIL single_release%0d got pulses=%0d idle=%0d want pulses=0 idle=1", i, pulses, dropped);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int busy_seen = 0;
    btn_raw = 5'b00001;
    repeat (3) begin tick(); if (btn_valid) pulses++; if (busy) busy_seen++; end
    btn_raw = 5'd0;
    repeat (12) begin tick(); if (btn_valid) pulses++; if (busy) busy_seen++; end
    total++; if (pulses != 0) $display("FAIL glitch_valid got %0d pulses want 0", pulses); else pass_cnt++;
    total++; if (busy_seen != 0) $display("FAIL glitch_busy got %0d busy cycles want 0", busy_seen); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit found;
    int pulses;
    bit dropped;
    btn_raw = 5'b00100;
    wait_valid(20, found);
    total++;
    if (!found || btn_code !== 3'd4) $display("FAIL hold_first got valid=%0d code=%0d want valid=1 code=4", found, btn_code);
    else pass_cnt++;
    btn_raw = 5'b10100;
    pulses = 0;
    repeat (15) begin tick(); if (btn_valid) pulses++; end
    total++; if (pulses != 0) $display("FAIL hold_second got %0d pulses want 0", pulses); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL hold_busy got %0d want 1", busy); else pass_cnt++;
    release_all(pulses, dropped);
    total++;
    if (pulses != 0 || !dropped) $display("FAIL hold_release got pulses=%0d idle=%0d want pulses=0 idle=1", pulses, dropped);
    else pass_cnt++;
    btn_raw = 5'b00011;
    wait_valid(20, found);
    total++;
    if (!found || btn_code !== 3'd0 || btn_multi !== 1'b1)
      $display("FAIL multi_press got valid=%0d code=%0d multi=%0d want valid=1 code=0 multi=1", found, btn_code, btn_multi);
    else pass_cnt++;
    release_all(pulses, dropped);
  endtask

  task automatic test_reset_midpress();
    do_reset();
    btn_raw = 5'b00010;
    for (int k = 1; k <= 12; k++) begin
      rst = (k == 5);
      tick();
      total++;
      if (btn_valid !== (k == 12)) $display("FAIL midreset_edge%0d got %0d want %0d", k, btn_valid, (k == 12));
      else pass_cnt++;
    end
    rst = 1'b0;
    total++; if (btn_code !== 3'd3) $display("FAIL midreset_code got %0d want 3", btn_code); else pass_cnt++;
    btn_raw = 5'd0;
    repeat (12) tick();
  endtask

`ifdef HIT_COMPARE_EN
  task automatic test_hit_compare();
    logic [2:0] moles [3] = '{3'd7, 3'd0, 3'd4};
    logic [4:0] pats  [3] = '{5'b00001, 5'b00001, 5'b10000};
    bit         want_hit [3] = '{1'b1, 1'b0, 1'b0};
    bit found;
    int pulses;
    bit dropped;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      mole_num = moles[t];
      btn_raw  = pats[t];
      wait_valid(20, found);
      total++;
      if (!found || hit !== want_hit[t] || miss !== !want_hit[t])
        $display("FAIL hit_case%0d got valid=%0d hit=%0d miss=%0d want valid=1 hit=%0d miss=%0d",
                 t, found, hit, miss, want_hit[t], !want_hit[t]);
      else pass_cnt++;
      release_all(pulses, dropped);
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] pat;
    int r;
    int reports = 0;
    do_reset();
    for (int seg = 0; seg < 70; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      pat = 5'd0;
      else if (r < 8) pat = 5'(1 << $urandom_range(0, 4));
      else if (r < 9) pat = 5'(1 << $urandom_range(0, 4)) | 5'(1 << $urandom_range(0, 4));
      else            pat = 5'($urandom_range(0, 31));
      btn_raw = pat;
`ifdef HIT_COMPARE_EN
      mole_num = 3'($urandom_range(0, 7));
`endif
      repeat ($urandom_range(1, 10)) begin
        tick();
        if (e_valid) reports++;
        total++;
        if (btn_valid !== e_valid || btn_code !== e_code || btn_multi !== e_multi || busy !== 1'(m_busy)
`ifdef HIT_COMPARE_EN
            || hit !== e_hit || miss !== e_miss
`endif
           )
          $display("FAIL random_seg%0d got v=%0d c=%0d m=%0d b=%0d want v=%0d c=%0d m=%0d b=%0d",
                   seg, btn_valid, btn_code, btn_multi, busy, e_valid, e_code, e_multi, m_busy);
        else pass_cnt++;
      end
    end
    total++;
    if (reports == 0) $display("FAIL random_activity got 0 reports want at least 1");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_bits();
    test_glitch();
    test_back_to_back();
    test_reset_midpress();
`ifdef HIT_COMPARE_EN
    test_hit_compare();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
